magsq_feeder: RTL and testbench

- Stage directly upstream of the square-root datapath in the spectrogram magnitude path.
- Accepts one signed FFT bin (re, im) per transaction and computes re² + im² with a serial shift-add squarer.
- Scales and saturates the sum to 8 bits and presents it as the square-root operand.
- Holds the operand under a go/ack handshake until the square-root controller has loaded it into its `a` register.

---
 rtl/magsq_pkg.sv | 18 +
 rtl/sumsq_serial.sv | 72 +++++++
 rtl/magsq_feeder.sv | 100 ++++++++++
 tb/tb_magsq_feeder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/magsq_pkg.sv
// magsq_pkg: definitions shared between the magnitude-squared feeder and the
// square-root controller downstream of it.
//   state_t : feeder sequencing states
//   OUT_W   : width of the square-root operand
//   SAT_MAX : largest operand value; larger results clip to it
package magsq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    SCALE = 2'd2,
    HAND  = 2'd3
  } state_t;

  localparam int OUT_W   = 8;
  localparam int SAT_MAX = 255;

endpackage

// File: rtl/sumsq_serial.sv
// sumsq_serial: serial shift-add engine computing |a|^2 + |b|^2, one
// multiplier bit per cycle. It takes W cycles after start.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   start        load a/b (two's complement) and clear the accumulator
//   a, b         signed W-bit operands
//   busy         accumulation in progress
//   done         high during the final accumulation cycle; sum is complete
//                after the edge that ends it
//   sum          accumulator, 2*W+1 bits
module sumsq_serial #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [2*W:0] sum
);

  localparam int SW = 2*W + 1;
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  ma, mb;
  logic [W-1:0]  abs_a, abs_b;
  logic [W-1:0]  sh_a, sh_b;
  logic [SW-1:0] acc;
  logic [SW-1:0] pp_a, pp_b;
  logic [CW-1:0] cnt;

  // |-2^(W-1)| = 2^(W-1) still fits in W unsigned bits.
  always_comb begin
    abs_a = a[W-1] ? (~a + W'(1)) : a;
    abs_b = b[W-1] ? (~b + W'(1)) : b;
  end

  // Partial products for the current multiplier bit. Bit selection is done
  // through a shift so cnt may be wider than the bit index.
  always_comb begin
    sh_a = ma >> cnt;
    sh_b = mb >> cnt;
    pp_a = sh_a[0] ? ({{(SW-W){1'b0}}, ma} << cnt) : '0;
    pp_b = sh_b[0] ? ({{(SW-W){1'b0}}, mb} << cnt) : '0;
  end

  assign done = busy && (cnt == CW'(W - 1));
  assign sum  = acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ma   <= '0;
      mb   <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      ma   <= abs_a;
      mb   <= abs_b;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= acc + pp_a + pp_b;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/magsq_feeder.sv
// magsq_feeder: takes one signed FFT bin (re, im), computes re^2 + im^2
// serially, scales by SHIFT and saturates to 8 bits, then holds the result
// as the square-root operand until the square-root controller acknowledges.
//
//   state | meaning
//   IDLE  | ready for a bin; in_ready=1
//   MUL   | serial squarer running, W cycles
//   SCALE | shift and saturate the sum into sq_val/sq_sat
//   HAND  | sq_go=1, operand held until sq_ack
//
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   in_valid/in_ready  bin handshake; in_re/in_im signed W-bit
//   sq_go              operand valid (level), held until sq_ack
//   sq_ack             one-cycle pulse: operand loaded downstream
//   sq_val, sq_sat     scaled operand and clip flag
module magsq_feeder
  import magsq_pkg::*;
#(
  parameter int W     = 8,
  parameter int SHIFT = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_re,
  input  logic [W-1:0]     in_im,
  output logic             sq_go,
  input  logic             sq_ack,
  output logic [OUT_W-1:0] sq_val,
  output logic             sq_sat
);

  localparam int SW = 2*W + 1;

  state_t        state;
  logic          start;
  logic          busy;
  logic          done;
  logic [SW-1:0] sum;
  logic [SW-1:0] scaled;

  assign start  = (state == IDLE) && in_valid;
  assign scaled = sum >> SHIFT;

  sumsq_serial #(.W(W)) u_sumsq (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (in_re),
    .b     (in_im),
    .busy  (busy),
    .done  (done),
    .sum   (sum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      sq_go    <= 1'b0;
      sq_val   <= '0;
      sq_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= MUL;
            in_ready <= 1'b0;
          end
        end
        MUL: begin
          // !busy is a fallback so the FSM can never stall here.
          if (done || !busy) state <= SCALE;
        end
        SCALE: begin
          if (scaled > SW'(SAT_MAX)) begin
            sq_val <= OUT_W'(SAT_MAX);
            sq_sat <= 1'b1;
          end else begin
            sq_val <= scaled[OUT_W-1:0];
            sq_sat <= 1'b0;
          end
          sq_go <= 1'b1;
          state <= HAND;
        end
        HAND: begin
          if (sq_ack) begin
            sq_go    <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_magsq_feeder.sv
module tb_magsq_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       sq_ack;
  logic [7:0] in_re, in_im;

  logic       rdy0, go0, sat0;
  logic [7:0] val0;
  logic       rdy1, go1, sat1;
  logic [7:0] val1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  magsq_feeder #(.W(8), .SHIFT(7)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .in_re(in_re), .in_im(in_im), .sq_go(go0), .sq_ack(sq_ack),
    .sq_val(val0), .sq_sat(sat0)
  );

  magsq_feeder #(.W(8), .SHIFT(0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .in_re(in_re), .in_im(in_im), .sq_go(go1), .sq_ack(sq_ack),
    .sq_val(val1), .sq_sat(sat1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the bin, then clip at 255.
  function automatic int clip(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  int exp_v0, exp_v1;
  bit exp_s0, exp_s1;

  // One full transaction: accept, count latency, check result, hold HAND for
  // 'hold' cycles with in_valid noise, then acknowledge. 'stray' injects
  // sq_ack pulses during IDLE (accept cycle) and MUL.
  task automatic run_bin(input int re, input int im, input int hold, input bit stray);
    int n;
    int sum;
    sum    = re*re + im*im;
    exp_v0 = clip(sum >> 7);
    exp_s0 = (sum >> 7) > 255;
    exp_v1 = clip(sum);
    exp_s1 = sum > 255;

    chk("ready_idle0", rdy0, 1);
    chk("ready_idle1", rdy1, 1);
    in_re    = 8'(re);
    in_im    = 8'(im);
    in_valid = 1'b1;
    sq_ack   = stray;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sq_ack   = 1'b0;
    in_re    = 8'($urandom);
    in_im    = 8'($urandom);
    chk("ready_busy", rdy0, 0);

    n = 0;
    while (!go0 && n < 20) begin
      sq_ack   = stray && (n == 3);
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    sq_ack   = 1'b0;
    in_valid = 1'b0;
    chk("latency", n, 9);
    chk("go1", go1, 1);
    chk("val_s7", val0, exp_v0);
    chk("sat_s7", sat0, exp_s0);
    chk("val_s0", val1, exp_v1);
    chk("sat_s0", sat1, exp_s1);

    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      in_re    = 8'($urandom);
      in_im    = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_go", go0, 1);
      chk("hold_ready", rdy0, 0);
      chk("hold_val0", val0, exp_v0);
      chk("hold_val1", val1, exp_v1);
      chk("hold_sat1", sat1, exp_s1);
    end

    // Ack together with a valid bin: the bin must not be taken on this edge.
    sq_ack   = 1'b1;
    in_valid = 1'b1;
    in_re    = 8'($urandom);
    in_im    = 8'($urandom);
    @(posedge clk); #1;
    sq_ack   = 1'b0;
    in_valid = 1'b0;
    chk("ack_go0", go0, 0);
    chk("ack_go1", go1, 0);
    chk("ack_ready", rdy0, 1);
    chk("after_val0", val0, exp_v0);
    chk("after_val1", val1, exp_v1);
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    sq_ack   = 1'b0;
    in_re    = '0;
    in_im    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_go", go0, 0);
    chk("rst_val", val0, 0);
    chk("rst_sat", sat0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", rdy0, 1);
    chk("rel_go", go0, 0);
    chk("rel_val1", val1, 0);

    run_bin(100, -50, 6, 1'b0);
    run_bin(-128, -128, 0, 1'b1);
    run_bin(3, 4, 2, 1'b0);
    run_bin(0, 0, 1, 1'b1);
    run_bin(-128, 127, 3, 1'b0);

    // Abort at MUL step 4: outputs must clear without waiting for a clock.
    in_re    = 8'(50);
    in_im    = 8'(50);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_go0", go0, 0);
    chk("abort_val0", val0, 0);
    chk("abort_sat0", sat0, 0);
    chk("abort_val1", val1, 0);
    chk("abort_sat1", sat1, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_bin(7, -7, 1, 1'b0);

    for (int k = 0; k < 12; k++) begin
      run_bin($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
              $urandom_range(0, 4), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
